mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the processor's data-memory side. It consumes the processor's store bus (`MemWrite`, `ALUResult` as address, `WriteData`, `MemorySelector`) and returns status on `ReadData`. Stored bytes are buffered in a small FIFO and serialised 8N1 on `tx`. It sits beside the data RAM in the top-level memory decode, and its `ReadData` is muxed by `MemorySelector`.

---
 rtl/mmio_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Register map (ALUResult[3:2]): 0 TXDATA (write pushes a byte), 1 STATUS,
// 2/3 reserved.
// Optional macro MMIO_UART_OVF_STICKY_EN adds a sticky overflow flag in
// STATUS bit3, cleared by writing STATUS with WriteData[3] = 1.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line high; pops the FIFO head into the shifter when non-empty
// S_START | start bit (line low) for CLKS_PER_BIT cycles
// S_DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// S_STOP  | stop bit (line high) for CLKS_PER_BIT cycles
module mmio_uart_tx #(
   parameter int FIFO_DEPTH   = 8,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   input  logic [1:0]  MemorySelector,
   output logic [31:0] ReadData,
   output logic        tx
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        r_state;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [7:0]    r_sh;
   logic [2:0]    r_idx;
   logic [BW-1:0] r_baud;
   logic          r_tx;

   state_t        w_state_nxt;
   logic [2:0]    w_idx_nxt;
   logic [BW-1:0] w_baud_nxt;
   logic          w_tx_nxt;
   logic          w_pop;
   logic [31:0]   w_status;
   logic          w_ovf;

   wire           w_sel      = (MemorySelector == 2'b10);
   wire           w_we       = w_sel & MemWrite;
   wire [1:0]     w_addr     = ALUResult[3:2];
   wire           w_full     = (r_count == CW'(FIFO_DEPTH));
   wire           w_empty    = (r_count == '0);
   wire           w_wr_tx    = w_we && (w_addr == 2'd0);
   wire           w_push     = w_wr_tx && !w_full;
   wire           w_drop     = w_wr_tx && w_full;
   wire           w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));
   wire           w_unused_bits = ^{ALUResult[31:4], ALUResult[1:0], WriteData[31:8], w_drop};

   // Next-state, pop request and next line value for the shifter.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_baud_nxt  = r_baud + 1'b1;
      w_tx_nxt    = 1'b1;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_baud_nxt = '0;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            w_tx_nxt = 1'b0;
            if (w_baud_end) begin
               w_state_nxt = S_DATA;
               w_idx_nxt   = 3'd0;
               w_baud_nxt  = '0;
            end
         end
         S_DATA: begin
            w_tx_nxt = r_sh[r_idx];
            if (w_baud_end) begin
               w_baud_nxt = '0;
               if (r_idx == 3'd7) w_state_nxt = S_STOP;
               else               w_idx_nxt   = r_idx + 3'd1;
            end
         end
         S_STOP: begin
            if (w_baud_end) begin
               w_state_nxt = S_IDLE;
               w_baud_nxt  = '0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Shifter state, counters and registered serial line.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_baud  <= '0;
         r_tx    <= 1'b1;
         r_sh    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_baud  <= w_baud_nxt;
         r_tx    <= w_tx_nxt;
         if (w_pop) r_sh <= r_mem[r_rd_ptr];
      end
   end

   // FIFO pointers and occupancy; a push is judged on the count before the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= WriteData[7:0];
   end

`ifdef MMIO_UART_OVF_STICKY_EN
   logic r_ovf;
   // Sticky overflow: a dropped push sets it and beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset)                                          r_ovf <= 1'b0;
      else if (w_drop)                                    r_ovf <= 1'b1;
      else if (w_we && (w_addr == 2'd1) && WriteData[3])  r_ovf <= 1'b0;
   end
   assign w_ovf = r_ovf;
`else
   assign w_ovf = 1'b0;
`endif

   // STATUS word and read mux; reads have no side effects.
   always_comb begin
      w_status          = '0;
      w_status[0]       = w_full;
      w_status[1]       = w_empty;
      w_status[2]       = (r_state != S_IDLE);
      w_status[3]       = w_ovf;
      w_status[4 +: CW] = r_count;
      ReadData          = '0;
      if (w_sel && (w_addr == 2'd1)) ReadData = w_status;
   end

   assign tx = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized and directed stimulus against a frame-timing
// reference model (byte queue plus remaining-frame-cycle counter).
module tb_mmio_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [1:0]  MemorySelector;
   logic [31:0] ReadData;
   logic        tx;

   int checks   = 0;
   int failures = 0;

   logic [7:0] m_q[$];
   int         m_busy = 0;
   logic [7:0] m_cur  = 8'h00;
   logic       m_tx   = 1'b1;
   logic       m_ovf  = 1'b0;

   mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .MemWrite       (MemWrite),
      .ALUResult      (ALUResult),
      .WriteData      (WriteData),
      .MemorySelector (MemorySelector),
      .ReadData       (ReadData),
      .tx             (tx)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s    = 32'(m_q.size()) << 4;
      s[0] = (m_q.size() == DEPTH);
      s[1] = (m_q.size() == 0);
      s[2] = (m_busy != 0);
      s[3] = m_ovf;
      return s;
   endfunction

   // Line level for the frame position implied by the remaining-cycle count.
   function automatic logic frame_tx();
      int p;
      if (m_busy == 0) return 1'b1;
      p = FRAME - m_busy;
      if (p < CPB)     return 1'b0;
      if (p < 9 * CPB) return m_cur[(p - CPB) / CPB];
      return 1'b1;
   endfunction

   task automatic model_edge();
      logic tx_n, pop, wr_tx, push, drop;
      if (reset) begin
         m_q.delete();
         m_busy = 0;
         m_ovf  = 1'b0;
         m_tx   = 1'b1;
      end else begin
         tx_n  = frame_tx();
         pop   = (m_busy == 0) && (m_q.size() > 0);
         wr_tx = MemWrite && (MemorySelector == 2'b10) && (ALUResult[3:2] == 2'd0);
         push  = wr_tx && (m_q.size() < DEPTH);
         drop  = wr_tx && (m_q.size() == DEPTH);
`ifdef MMIO_UART_OVF_STICKY_EN
         if (drop) m_ovf = 1'b1;
         else if (MemWrite && (MemorySelector == 2'b10) && (ALUResult[3:2] == 2'd1) && WriteData[3])
            m_ovf = 1'b0;
`else
         if (drop) m_ovf = 1'b0;
`endif
         if (m_busy > 0) m_busy--;
         if (pop) begin
            m_cur  = m_q.pop_front();
            m_busy = FRAME;
         end
         if (push) m_q.push_back(WriteData[7:0]);
         m_tx = tx_n;
      end
   endtask

   task automatic step();
      logic [31:0] exp_rd;
      @(negedge clk);
      exp_rd = 32'h0;
      if ((MemorySelector == 2'b10) && (ALUResult[3:2] == 2'd1)) exp_rd = exp_status();
      check_val("read_data", ReadData, exp_rd);
      @(posedge clk);
      model_edge();
      #1;
      check_val("tx_line", {31'h0, tx}, {31'h0, m_tx});
   endtask

   task automatic drive(input logic we, input logic [1:0] ms, input logic [31:0] addr,
                        input logic [31:0] data);
      MemWrite       = we;
      MemorySelector = ms;
      ALUResult      = addr;
      WriteData      = data;
   endtask

   task automatic idle_read(input int n);
      drive(1'b0, 2'b10, 32'h4, 32'h0);
      repeat (n) step();
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 2'b10, 32'h4, 32'h0);
      @(posedge clk);
      #1;
      repeat (2) step();
      reset = 1'b0;
      check_val("reset_status", ReadData, 32'h2);
      check_val("reset_tx", {31'h0, tx}, 32'h1);
      idle_read(3);

      // single byte
      drive(1'b1, 2'b10, 32'h0, 32'hA5);
      step();
      idle_read(50);

      // five back-to-back: fills the FIFO exactly
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 2'b10, 32'h0, 32'(i));
         step();
      end
      drive(1'b0, 2'b10, 32'h4, 32'h0);
      #1;
      check_val("burst5_status", ReadData & 32'h71, 32'h41);
      idle_read(230);

      // six back-to-back: last one dropped
      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, 2'b10, 32'h0, 32'(i));
         step();
      end
      idle_read(10);
      drive(1'b1, 2'b10, 32'h4, 32'h8);
      step();
      idle_read(260);

      // unselected and reserved stores
      drive(1'b1, 2'b00, 32'h0, 32'h11); step();
      drive(1'b1, 2'b01, 32'h0, 32'h22); step();
      drive(1'b1, 2'b10, 32'h8, 32'h33); step();
      drive(1'b1, 2'b10, 32'hC, 32'h44); step();
      drive(1'b0, 2'b00, 32'h4, 32'h0);
      repeat (10) step();

      // reset during DATA bit 3 with two bytes queued
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'b10, 32'h0, 32'h5A + 32'(i));
         step();
      end
      idle_read(17);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_val("midframe_reset_status", ReadData, 32'h2);
      check_val("midframe_reset_tx", {31'h0, tx}, 32'h1);
      idle_read(60);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         logic [31:0] a;
         reset = ($urandom_range(0, 499) == 0);
         a = $urandom();
         a[3:2] = 2'($urandom_range(0, 3));
         drive(($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10,
               a, $urandom());
         step();
      end
      reset = 1'b0;
      idle_read(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
